// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller and the external decoder.
// Both sides use BLANK_CODE, so a blanked slot always decodes to dark segments.
package seg7_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

    // Ceiling log2, never below 1 so every index or counter has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Active-high segments {g,f,e,d,c,b,a}, common cathode. Codes above 9 are dark.
    function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_prescaler.sv
// Slot prescaler: counts 0..SCAN_DIV-1 per digit slot, held at 0 while en is low.
// slot_end describes the current count; slot_last_d and in_dead describe the count being loaded.
module scan_prescaler
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic slot_end,
    output logic slot_last_d,
    output logic in_dead
);

    localparam int CNT_W = clog2(SCAN_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        slot_end = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d    = '0;
        if (en && !slot_end) cnt_d = cnt_q + CNT_W'(1);
        slot_last_d = (cnt_d == CNT_W'(SCAN_DIV - 1));
        in_dead     = (int'(cnt_d) < BLANK_CYC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for NDIG common-cathode digits sharing one decoder.
// Outputs are registered from next-state values, so they track cnt/idx/snap with no lag.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     lzb,
    input  logic [BCD_W*NDIG-1:0]    bcd_in,
    output logic [BCD_W-1:0]         code,
    output logic [NDIG-1:0]          dig_en,
    output logic [clog2(NDIG)-1:0]   dig_idx,
    output logic                     frame_tick
);

    localparam int IDX_W = clog2(NDIG);

    logic                  slot_end, slot_last_d, in_dead, wrap;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BCD_W*NDIG-1:0] snap_q, snap_d;
    logic [BCD_W-1:0]      code_q, code_d;
    logic [NDIG-1:0]       dig_en_q, dig_en_d;
    logic                  frame_tick_q, frame_tick_d;
    logic [BCD_W-1:0]      snap_dig [NDIG];
    logic [NDIG-1:0]       blank;
    logic                  zero_run;

    scan_prescaler #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_prescaler (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .slot_end    (slot_end),
        .slot_last_d (slot_last_d),
        .in_dead     (in_dead)
    );

    // Snapshot is only refreshed at frame wrap so a counter update cannot tear a frame.
    always_comb begin
        wrap  = slot_end && (idx_q == IDX_W'(NDIG - 1));
        idx_d = '0;
        if (en) begin
            if (wrap)          idx_d = '0;
            else if (slot_end) idx_d = idx_q + IDX_W'(1);
            else               idx_d = idx_q;
        end
        snap_d = (!en || wrap) ? bcd_in : snap_q;
    end

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
        assign snap_dig[gi] = snap_d[gi*BCD_W +: BCD_W];
    end

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int k = NDIG - 1; k >= 1; k--) begin
            zero_run = zero_run && (snap_dig[k] == '0);
            blank[k] = lzb && zero_run;
        end
    end

    always_comb begin
        code_d   = BLANK_CODE;
        dig_en_d = '0;
        if (en && !in_dead) begin
            dig_en_d[idx_d] = 1'b1;
            code_d          = blank[idx_d] ? BLANK_CODE : snap_dig[idx_d];
        end
        frame_tick_d = en && (idx_d == IDX_W'(NDIG - 1)) && slot_last_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            snap_q       <= '0;
            code_q       <= BLANK_CODE;
            dig_en_q     <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            code_q       <= code_d;
            dig_en_q     <= dig_en_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign code       = code_q;
    assign dig_en     = dig_en_q;
    assign dig_idx    = idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench: a 4-digit instance (SCAN_DIV=8, BLANK_CYC=2) and a 3-digit
// instance (SCAN_DIV=5, BLANK_CYC=0) driven from one linear stimulus sequence.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        lzb;
    logic [15:0] bcd4;
    logic [11:0] bcd3;

    logic [3:0]  code4;
    logic [3:0]  dig_en4;
    logic [1:0]  dig_idx4;
    logic        frame_tick4;

    logic [3:0]  code3;
    logic [2:0]  dig_en3;
    logic [1:0]  dig_idx3;
    logic        frame_tick3;

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(.NDIG(4), .SCAN_DIV(8), .BLANK_CYC(2)) u4 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .lzb        (lzb),
        .bcd_in     (bcd4),
        .code       (code4),
        .dig_en     (dig_en4),
        .dig_idx    (dig_idx4),
        .frame_tick (frame_tick4)
    );

    seg7_scan_ctrl #(.NDIG(3), .SCAN_DIV(5), .BLANK_CYC(0)) u6 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .lzb        (lzb),
        .bcd_in     (bcd3),
        .code       (code3),
        .dig_en     (dig_en3),
        .dig_idx    (dig_idx3),
        .frame_tick (frame_tick3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold en low across release so the first edge loads the snapshot; returns at cycle 0 of slot 0.
    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        chk("rst_dig_en", 0, 32'(dig_en4), 32'h0);
        chk("rst_code", 0, 32'(code4), 32'hF);
        chk("rst_idx", 0, 32'(dig_idx4), 32'h0);
        chk("rst_ftick", 0, 32'(frame_tick4), 32'h0);
        rst = 1'b0;
        tick();
        en = 1'b1;
    endtask

    // From cycle 0 of a frame on u4, check ncyc cycles against expected per-slot codes.
    task automatic frame(input string tag, input logic [3:0] c0, input logic [3:0] c1,
                         input logic [3:0] c2, input logic [3:0] c3, input int ncyc,
                         input int chg_at, input logic [15:0] chg_val);
        logic [3:0] codes [4];
        int s;
        int k;
        codes[0] = c0;
        codes[1] = c1;
        codes[2] = c2;
        codes[3] = c3;
        for (int c = 0; c < ncyc; c++) begin
            s = c / 8;
            k = c % 8;
            chk({tag, "_dig_en"}, c, 32'(dig_en4), (k >= 2) ? (32'h1 << s) : 32'h0);
            chk({tag, "_code"}, c, 32'(code4), (k >= 2) ? 32'(codes[s]) : 32'hF);
            chk({tag, "_idx"}, c, 32'(dig_idx4), 32'(s));
            chk({tag, "_ftick"}, c, 32'(frame_tick4), (c == 31) ? 32'h1 : 32'h0);
            $display("%s cycle %0d: dig_en=%b code=%h idx=%0d ftick=%b",
                     tag, c, dig_en4, code4, dig_idx4, frame_tick4);
            if (c == chg_at) bcd4 = chg_val;
            tick();
        end
    endtask

    initial begin
        int s;
        rst  = 1'b1;
        en   = 1'b0;
        lzb  = 1'b0;
        bcd4 = 16'h1234;
        bcd3 = 12'h987;

        // Scan order, dead time, frame tick, and tear-free snapshot update.
        do_reset();
        frame("s1", 4'h4, 4'h3, 4'h2, 4'h1, 32, 12, 16'h5678);
        frame("s2", 4'h8, 4'h7, 4'h6, 4'h5, 32, -1, 16'h0);

        // Leading-zero blanking keeps dig_en one-hot and never blanks digit 0.
        lzb  = 1'b1;
        bcd4 = 16'h0040;
        en   = 1'b0;
        tick();
        chk("s3_off_dig_en", 0, 32'(dig_en4), 32'h0);
        chk("s3_off_code", 0, 32'(code4), 32'hF);
        en = 1'b1;
        frame("s3a", 4'h0, 4'h4, 4'hF, 4'hF, 32, -1, 16'h0);
        bcd4 = 16'h0000;
        en   = 1'b0;
        tick();
        en = 1'b1;
        frame("s3b", 4'h0, 4'hF, 4'hF, 4'hF, 32, -1, 16'h0);
        lzb = 1'b0;

        // Drop en mid-slot 1; restart must use the freshly loaded (partly invalid) digits.
        bcd4 = 16'h1234;
        en   = 1'b0;
        tick();
        en = 1'b1;
        frame("s4a", 4'h4, 4'h3, 4'h2, 4'h1, 13, -1, 16'h0);
        bcd4 = 16'h9A76;
        en   = 1'b0;
        tick();
        chk("s4_drop_dig_en", 13, 32'(dig_en4), 32'h0);
        chk("s4_drop_code", 13, 32'(code4), 32'hF);
        chk("s4_drop_idx", 13, 32'(dig_idx4), 32'h0);
        chk("s4_drop_ftick", 13, 32'(frame_tick4), 32'h0);
        en = 1'b1;
        frame("s4b", 4'h6, 4'h7, 4'hA, 4'h9, 32, -1, 16'h0);

        // Asynchronous reset in the middle of slot 2, away from any clock edge.
        bcd4 = 16'h1234;
        en   = 1'b0;
        tick();
        en = 1'b1;
        frame("s5a", 4'h4, 4'h3, 4'h2, 4'h1, 21, -1, 16'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("s5_async_dig_en", 20, 32'(dig_en4), 32'h0);
        chk("s5_async_code", 20, 32'(code4), 32'hF);
        chk("s5_async_idx", 20, 32'(dig_idx4), 32'h0);
        chk("s5_async_ftick", 20, 32'(frame_tick4), 32'h0);
        $display("s5 async reset: dig_en=%b code=%h idx=%0d", dig_en4, code4, dig_idx4);
        do_reset();
        frame("s5b", 4'h4, 4'h3, 4'h2, 4'h1, 32, -1, 16'h0);

        // Three digits, no dead time: dig_en always lit after the first edge, 15-cycle frame.
        do_reset();
        for (int c = 0; c < 31; c++) begin
            if (c >= 1) begin
                s = (c / 5) % 3;
                chk("s6_dig_en", c, 32'(dig_en3), 32'h1 << s);
                chk("s6_code", c, 32'(code3), (s == 0) ? 32'h7 : (s == 1) ? 32'h8 : 32'h9);
                chk("s6_idx", c, 32'(dig_idx3), 32'(s));
                chk("s6_ftick", c, 32'(frame_tick3), ((c % 15) == 14) ? 32'h1 : 32'h0);
                $display("s6 cycle %0d: dig_en=%b code=%h idx=%0d ftick=%b",
                         c, dig_en3, code3, dig_idx3, frame_tick3);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
